// File: rtl/ysyx_041514_clint_pkg.sv
// Shared constants and decode helper for the core-local interruptor.
// Addresses mirror the system configuration; keep both in sync if the memory map moves.
package ysyx_041514_clint_pkg;

  localparam logic [31:0] CLINT_MTIME_ADDR    = 32'h0200_BFF8;
  localparam logic [31:0] CLINT_MTIMECMP_ADDR = 32'h0200_4000;
  localparam logic [63:0] CLINT_MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int          CLINT_TICK_DIV      = 1;
  localparam int          CLINT_DIV_W         = 8;

  typedef enum logic [1:0] {
    SEL_NONE     = 2'd0,
    SEL_MTIME    = 2'd1,
    SEL_MTIMECMP = 2'd2
  } clint_sel_e;

  // Full 32-bit match; aliases and partial decodes are deliberately not supported.
  function automatic clint_sel_e clint_decode(
    input logic [31:0] addr,
    input logic [31:0] mtime_addr,
    input logic [31:0] mtimecmp_addr
  );
    clint_sel_e sel;
    sel = SEL_NONE;
    if (addr == mtime_addr) begin
      sel = SEL_MTIME;
    end else if (addr == mtimecmp_addr) begin
      sel = SEL_MTIMECMP;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ysyx_041514_clint_tick.sv
// Prescaler for mtime: pulses tick_o once every TICK_DIV core clocks.
// clr_i restarts the count so the next pulse lands a full period later.
module ysyx_041514_clint_tick #(
  parameter int TICK_DIV = 1,
  parameter int DIV_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_wrap;

  // With TICK_DIV == 1 the counter never leaves zero, so the tick is constant.
  assign w_wrap = (r_cnt == DIV_W'(TICK_DIV - 1));
  assign tick_o = w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr_i || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/ysyx_041514_clint.sv
// Core-local interruptor: mtime/mtimecmp registers, single-cycle load/store port
// for the memory stage, and the registered machine timer interrupt.
module ysyx_041514_clint
  import ysyx_041514_clint_pkg::*;
#(
  parameter logic [31:0] MTIME_ADDR    = CLINT_MTIME_ADDR,
  parameter logic [31:0] MTIMECMP_ADDR = CLINT_MTIMECMP_ADDR,
  parameter int          TICK_DIV      = CLINT_TICK_DIV,
  parameter int          DIV_W         = CLINT_DIV_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] clint_addr_i,
  input  logic        clint_valid_i,
  input  logic        clint_write_valid_i,
  input  logic [63:0] clint_wdata_i,
  output logic [63:0] clint_rdata_o,
  output logic [63:0] mtime_o,
  output logic        mtip_o
);

  clint_sel_e  w_sel;
  logic        w_wr_mtime;
  logic        w_wr_mtimecmp;
  logic        w_tick;
  logic [63:0] w_mtime_next;
  logic [63:0] w_mtimecmp_next;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_mtip;

  assign w_sel = clint_valid_i
               ? clint_decode(clint_addr_i, MTIME_ADDR, MTIMECMP_ADDR)
               : SEL_NONE;

  assign w_wr_mtime    = clint_write_valid_i && (w_sel == SEL_MTIME);
  assign w_wr_mtimecmp = clint_write_valid_i && (w_sel == SEL_MTIMECMP);

  // An mtime store restarts the prescaler, so a stalled store keeps it parked at zero.
  ysyx_041514_clint_tick #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (w_wr_mtime),
    .tick_o (w_tick)
  );

  always_comb begin
    w_mtime_next = r_mtime;
    if (w_wr_mtime) begin
      w_mtime_next = clint_wdata_i;
    end else if (w_tick) begin
      w_mtime_next = r_mtime + 64'd1;
    end
  end

  always_comb begin
    w_mtimecmp_next = r_mtimecmp;
    if (w_wr_mtimecmp) begin
      w_mtimecmp_next = clint_wdata_i;
    end
  end

  // mtip compares the values being loaded, so it tracks writes and ticks with no extra stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= CLINT_MTIMECMP_RESET;
      r_mtip     <= 1'b0;
    end else begin
      r_mtime    <= w_mtime_next;
      r_mtimecmp <= w_mtimecmp_next;
      r_mtip     <= (w_mtime_next >= w_mtimecmp_next);
    end
  end

  always_comb begin
    clint_rdata_o = '0;
    case (w_sel)
      SEL_MTIME:    clint_rdata_o = r_mtime;
      SEL_MTIMECMP: clint_rdata_o = r_mtimecmp;
      default:      clint_rdata_o = '0;
    endcase
  end

  assign mtime_o = r_mtime;
  assign mtip_o  = r_mtip;

endmodule

// File: tb/tb_ysyx_041514_clint.sv
// Self-checking bench for ysyx_041514_clint: one instance with a divide-by-4
// prescaler and one ticking every cycle, both checked against a behavioural model.
module tb_ysyx_041514_clint;

  localparam logic [31:0] ADDR_MTIME = 32'h0200_BFF8;
  localparam logic [31:0] ADDR_CMP   = 32'h0200_4000;
  localparam logic [31:0] ADDR_OTHER = 32'h0200_0000;
  localparam logic [63:0] ONES       = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid [2];
  logic        write [2];
  logic [31:0] addr  [2];
  logic [63:0] wdata [2];
  logic [63:0] rdata [2];
  logic [63:0] mtime [2];
  logic        mtip  [2];

  logic [63:0] mMtime [2];
  logic [63:0] mCmp   [2];
  logic        mMtip  [2];
  int          anchor [2];
  int          cyc;

  int testsRun = 0;
  int failures = 0;

  // Index 0 runs mtime at a quarter of the core clock, index 1 every clock.
  ysyx_041514_clint #(.TICK_DIV(4)) dutSlow (
    .clk                 (clock),
    .rst                 (reset),
    .clint_addr_i        (addr[0]),
    .clint_valid_i       (valid[0]),
    .clint_write_valid_i (write[0]),
    .clint_wdata_i       (wdata[0]),
    .clint_rdata_o       (rdata[0]),
    .mtime_o             (mtime[0]),
    .mtip_o              (mtip[0])
  );

  ysyx_041514_clint #(.TICK_DIV(1)) dutFast (
    .clk                 (clock),
    .rst                 (reset),
    .clint_addr_i        (addr[1]),
    .clint_valid_i       (valid[1]),
    .clint_write_valid_i (write[1]),
    .clint_wdata_i       (wdata[1]),
    .clint_rdata_o       (rdata[1]),
    .mtime_o             (mtime[1]),
    .mtip_o              (mtip[1])
  );

  // Free-running core clock, 10 time units per period.
  always #5 clock = ~clock;

  function automatic int divOf(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mMtime[i] = 64'd0;
      mCmp[i]   = ONES;
      mMtip[i]  = 1'b0;
      anchor[i] = cyc;
    end
  endtask

  // A tick lands whenever a whole number of periods has elapsed since the last reset
  // or mtime store; a store that cycle wins and becomes the new anchor.
  task automatic modelStep();
    logic hitT;
    logic hitC;
    logic tick;
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      hitT = valid[i] && write[i] && (addr[i] == ADDR_MTIME);
      hitC = valid[i] && write[i] && (addr[i] == ADDR_CMP);
      tick = ((cyc - anchor[i]) % divOf(i)) == 0;
      if (hitT) begin
        mMtime[i] = wdata[i];
        anchor[i] = cyc;
      end else if (tick) begin
        mMtime[i] = mMtime[i] + 64'd1;
      end
      if (hitC) begin
        mCmp[i] = wdata[i];
      end
      mMtip[i] = (mMtime[i] >= mCmp[i]);
    end
  endtask

  function automatic logic [63:0] expRdata(input int i);
    if (!valid[i]) return 64'd0;
    if (addr[i] == ADDR_MTIME) return mMtime[i];
    if (addr[i] == ADDR_CMP) return mCmp[i];
    return 64'd0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun = testsRun + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int i, input logic v, input logic w, input logic [31:0] a, input logic [63:0] d);
    valid[i] = v;
    write[i] = w;
    addr[i]  = a;
    wdata[i] = d;
  endtask

  task automatic idle(input int i);
    applyStimulus(i, 1'b0, 1'b0, 32'd0, 64'd0);
  endtask

  // Advance n active edges and park 2 units after the last one, clear of both edges.
  task automatic stepClock(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // The model follows the DUT: async reset on its rising edge, otherwise one step per clock.
  initial begin
    cyc = 0;
    modelReset();
    forever begin
      @(posedge clock or posedge reset);
      if (reset) modelReset();
      else modelStep();
    end
  end

  // Every cycle out of reset, all outputs of both instances are checked on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        for (int i = 0; i < 2; i++) begin
          checkOutput($sformatf("model mtime[%0d]", i), mtime[i], mMtime[i]);
          checkOutput($sformatf("model mtip[%0d]", i), {63'd0, mtip[i]}, {63'd0, mMtip[i]});
          checkOutput($sformatf("model rdata[%0d]", i), rdata[i], expRdata(i));
        end
      end
    end
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    idle(0);
    idle(1);
    stepClock(2);
    reset = 1'b0;
    checkOutput("reset mtime slow", mtime[0], 64'd0);
    checkOutput("reset mtime fast", mtime[1], 64'd0);

    stepClock(10);
    checkOutput("div4 ten clocks", mtime[0], 64'd2);
    checkOutput("div4 mtip low", {63'd0, mtip[0]}, 64'd0);
    applyStimulus(0, 1'b1, 1'b0, ADDR_CMP, 64'd0);
    #1;
    checkOutput("reset mtimecmp read", rdata[0], ONES);
    stepClock(1);
    idle(0);

    applyStimulus(1, 1'b1, 1'b1, ADDR_MTIME, 64'd5);
    stepClock(1);
    checkOutput("fast mtime=5", mtime[1], 64'd5);
    applyStimulus(1, 1'b1, 1'b1, ADDR_CMP, 64'd20);
    stepClock(1);
    idle(1);
    checkOutput("fast after cmp write", mtime[1], 64'd6);
    stepClock(13);
    checkOutput("fast mtime 19", mtime[1], 64'd19);
    checkOutput("mtip before 20", {63'd0, mtip[1]}, 64'd0);
    stepClock(1);
    checkOutput("fast mtime 20", mtime[1], 64'd20);
    checkOutput("mtip at 20", {63'd0, mtip[1]}, 64'd1);
    applyStimulus(1, 1'b1, 1'b1, ADDR_CMP, 64'd100);
    stepClock(1);
    idle(1);
    checkOutput("mtip falls", {63'd0, mtip[1]}, 64'd0);

    applyStimulus(0, 1'b1, 1'b1, ADDR_MTIME, 64'h50);
    stepClock(1);
    idle(0);
    stepClock(3);
    checkOutput("slow held 0x50", mtime[0], 64'h50);
    applyStimulus(0, 1'b1, 1'b1, ADDR_MTIME, 64'h1000);
    #1;
    checkOutput("same-cycle read old", rdata[0], 64'h50);
    stepClock(1);
    idle(0);
    checkOutput("write beats tick", mtime[0], 64'h1000);
    stepClock(3);
    checkOutput("no early increment", mtime[0], 64'h1000);
    stepClock(1);
    checkOutput("increment after 4", mtime[0], 64'h1001);

    applyStimulus(1, 1'b1, 1'b1, ADDR_CMP, 64'd0);
    stepClock(1);
    applyStimulus(1, 1'b1, 1'b1, ADDR_MTIME, ONES);
    stepClock(1);
    idle(1);
    checkOutput("fast all ones", mtime[1], ONES);
    stepClock(1);
    checkOutput("wrap to zero", mtime[1], 64'd0);
    checkOutput("mtip at 0>=0", {63'd0, mtip[1]}, 64'd1);

    applyStimulus(0, 1'b1, 1'b1, ADDR_OTHER, 64'hDEAD);
    #1;
    checkOutput("other addr rdata", rdata[0], 64'd0);
    stepClock(1);
    applyStimulus(0, 1'b0, 1'b0, ADDR_MTIME, 64'd0);
    #1;
    checkOutput("invalid read", rdata[0], 64'd0);
    applyStimulus(0, 1'b1, 1'b0, ADDR_CMP, 64'd0);
    #1;
    checkOutput("cmp untouched", rdata[0], ONES);
    stepClock(1);

    applyStimulus(0, 1'b1, 1'b1, ADDR_MTIME, 64'd7);
    for (int k = 0; k < 5; k++) begin
      stepClock(1);
      checkOutput($sformatf("stalled store %0d", k), mtime[0], 64'd7);
    end
    idle(0);
    stepClock(3);
    checkOutput("after release", mtime[0], 64'd7);
    stepClock(1);
    checkOutput("first tick after release", mtime[0], 64'd8);

    #1;
    reset = 1'b1;
    #1;
    checkOutput("async mtime slow", mtime[0], 64'd0);
    checkOutput("async mtime fast", mtime[1], 64'd0);
    checkOutput("async mtip fast", {63'd0, mtip[1]}, 64'd0);
    checkOutput("async mtip slow", {63'd0, mtip[0]}, 64'd0);
    stepClock(1);
    reset = 1'b0;
    stepClock(5);
    checkOutput("post-reset slow", mtime[0], 64'd1);
    checkOutput("post-reset fast", mtime[1], 64'd5);

    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_041514_clint.md
Name: ysyx_041514_clint

Overview:
Core-local interruptor: the responder on the memory stage's CLINT port. It holds the 64-bit mtime and mtimecmp registers, services single-cycle reads and writes from the memory stage, and raises the machine timer interrupt (mtip) toward the CSR/trap logic. mtime advances on a prescaled tick generated from the core clock.

Parameters:
MTIME_ADDR, 32'h0200_BFF8, byte address of mtime; must equal `ysyx_041514_MTIME_ADDR
MTIMECMP_ADDR, 32'h0200_4000, byte address of mtimecmp; must equal `ysyx_041514_MTIMECMP_ADDR
TICK_DIV, 1, core clocks per mtime increment (>=1; 1 = every cycle)
DIV_W, 8, prescaler counter width; TICK_DIV <= 2^DIV_W

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
clint_addr_i  in  32  access address, full 32-bit compare
clint_valid_i  in  1  memory stage is accessing a CLINT address this cycle
clint_write_valid_i  in  1  1 = store, 0 = load; qualified by clint_valid_i
clint_wdata_i  in  64  store data, always full 64 bits, no byte mask
clint_rdata_o  out  64  read data, combinational
mtime_o  out  64  current mtime, for debug/difftest
mtip_o  out  1  machine timer interrupt pending, registered

Behaviour:
- Reset (async, rst=1): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0, mtip_o=0. Takes effect immediately and overrides any in-flight access or tick. The first increment occurs TICK_DIV clocks after rst deasserts.
- Prescaler: counts 0..TICK_DIV-1 and asserts tick when count==TICK_DIV-1, then wraps to 0. With TICK_DIV=1, tick is constant 1.
- mtime update priority, per clock:
  1. write hit on MTIME_ADDR (valid & write & addr==MTIME_ADDR): mtime<=wdata and prescaler<=0; the tick that cycle is discarded.
  2. else if tick: mtime<=mtime+1, modulo 2^64, so all-ones wraps to 0.
  3. else hold.
- mtimecmp: loaded with wdata on a write hit to MTIMECMP_ADDR, otherwise held. Not affected by ticks.
- Writes to any other address while clint_valid_i=1 are ignored with no state change.
- Writes are idempotent by design. The memory stage may hold a store for several cycles during a stall, and each cycle rewrites the register.
  - A held mtime store keeps mtime pinned to wdata and the prescaler at 0 until the store retires.
- Read: clint_rdata_o is combinational, same cycle as clint_valid_i.
  - Returns mtime or mtimecmp for a matching address; any other address, or clint_valid_i=0, returns 64'h0.
  - A read returns the pre-update register value. A same-cycle write is not forwarded; the write is visible on the next cycle.
- mtip_o: registered, mtip_o <= (mtime_next >= mtimecmp_next), unsigned 64-bit compare on the values being loaded this edge.
  - It is therefore valid on the same edge that mtime or mtimecmp changes: one-cycle latency from the write or tick, with no extra stage.
  - It deasserts on the edge at which a write raises mtimecmp above mtime.
  - It is level-sensitive, with no latching beyond the compare.
- mtime_o = mtime register.
- No handshake and no stall output. Every access completes in the cycle it is presented.

Decomposition:
- Addresses come from the existing `ysyx_041514_MTIME_ADDR / `ysyx_041514_MTIMECMP_ADDR in sysconfig.v; the parameters default to them.
- Add `ysyx_041514_MTIMECMP_RESET (all ones) and `ysyx_041514_CLINT_TICK_DIV to sysconfig.v.
- One sub-module: ysyx_041514_clint_tick, the prescaler.
  - Ports: clk, rst, clr_i (prescaler<=0), tick_o.
  - Parameters: TICK_DIV, DIV_W.
- The top level holds the registers, decode, read mux and compare.

Test Plan:
- Reset: after rst pulse with TICK_DIV=4, run 10 clocks -> mtime_o=2 (ticks at clocks 4 and 8), mtip_o=0, read of MTIMECMP_ADDR -> 64'hFFFF_FFFF_FFFF_FFFF.
- Interrupt: TICK_DIV=1, write mtimecmp=20 at mtime=5 -> mtip_o rises on the edge where mtime becomes 20, not before. Then write mtimecmp=100 -> mtip_o falls the next edge.
- Write precedence: TICK_DIV=4, write mtime=64'h1000 on a tick cycle -> mtime=0x1000 (not 0x1001). Next increment follows 4 clocks later. A same-cycle read returns the old value.
- Wrap: write mtime=64'hFFFF_FFFF_FFFF_FFFF, mtimecmp=0 -> after one tick mtime=0 and mtip_o stays 1 (0>=0).
- Decode: valid store to 32'h0200_0000 with wdata=0xDEAD -> no register changes, rdata=0. A read with clint_valid_i=0 at MTIME_ADDR -> 0.
- Stalled store and async reset: hold an mtime store of 7 for 5 cycles -> mtime stays 7, then increments after release. Assert rst mid-clock -> mtime=0 and mtip_o=0 immediately, without waiting for a clock edge.
